flash_cfg: RTL and testbench
============================

Name: flash_cfg

Overview:
- SPI-flash settings reader sitting directly upstream of the top-level video-mode select.
- After reset (or on request), it reads NBYTES configuration bytes from the boot flash with a standard 0x03 READ command.
- It holds those bytes and the derived VGA-enable bit stable for the rest of the session.
- It owns the flash SPI pins (fshCs/fshCk/fshMosi/fshMiso) and replaces the ad-hoc counter sequencer currently in the top level.

Parameters:
- ADDR, 24'h00704D: flash byte address of first configuration byte.
- NBYTES, 2: number of bytes read, 1..8.
- VGA_IDX, 1: index of byte whose bits [1:0] select VGA (2'b10 = VGA on).
- AUTO, 1: 1 = start a read automatically on reset release; 0 = wait for start.

Ports:
- clock, input, 1: system clock (56 MHz).
- reset, input, 1: asynchronous, active-low reset.
- ce, input, 1: clock enable; every SPI half-bit advances on one ce pulse (7 MHz nominal).
- start, input, 1: one-clock request to (re)read; ignored while busy.
- busy, output, 1: transaction in progress.
- valid, output, 1: cfgQ holds a completed read.
- cfgVga, output, 1: byte VGA_IDX bits [1:0] == 2'b10, qualified by valid.
- cfgQ, output, 8*NBYTES: byte k at bits [8k+7:8k], with k=0 at ADDR.
- fshCs, output, 1: flash chip select, active-low.
- fshCk, output, 1: SPI clock, mode 0.
- fshMosi, output, 1: serial data to flash.
- fshMiso, input, 1: serial data from flash.

Behaviour:
- Reset (reset=0, async) sets: fshCs=1, fshCk=0, fshMosi=0, busy=0, valid=0, cfgVga=0, cfgQ=0, state IDLE.
- States: IDLE -> SEL -> XFER -> DESEL -> IDLE. WAKE precedes SEL when the option is enabled.
- All state and SPI updates occur only on clock edges with ce=1. start is sampled on any clock.
- Launch condition: IDLE with start=1, or the first ce after reset release when AUTO=1. Launch sets busy=1 and goes to SEL. valid is not cleared; the old cfgQ persists until overwritten.
- SEL: fshCs<=0 for one ce, then XFER.
- XFER:
  - Shifts 4+NBYTES bytes: 0x03, ADDR[23:16], ADDR[15:8], ADDR[7:0], then NBYTES dummy-out bytes. fshMosi=0 during read bytes.
  - Each bit takes 2 ce. Phase A: fshCk=0, fshMosi=next bit, MSB first. Phase B: fshCk=1, fshMiso sampled into the shift register.
  - One byte = 16 ce. Byte counter 0..3+NBYTES; bit counter 0..7 wraps per byte.
  - At the end of each read byte, the shift register is written to cfgQ slot (byte counter - 4).
- DESEL: fshCk=0, fshCs<=1. On the same ce: valid<=1, busy<=0, cfgVga updated. Then IDLE.
- cfgVga may only change on a DESEL ce; it never glitches mid-transfer.
- Latency with the option disabled, launch ce to valid: 1 + 16*(4+NBYTES) + 1 ce. For NBYTES=2 that is 98 ce.
- start while busy: dropped, not queued.
- start and launch on the same ce as DESEL: new launch occurs on the next ce from IDLE.
- Reset mid-transfer: immediate return to reset values with fshCs=1. The flash sees an aborted READ, which is legal.
- fshCk high time and low time are each exactly one ce period. fshCs is stable across every fshCk edge.

Optional Feature:
- Macro FLASH_CFG_WAKE_EN.
- When defined:
  - Every launch first enters WAKE. WAKE asserts fshCs=0, shifts 0xAB (release from deep power-down) in 16 ce, then sets fshCs=1.
  - A TRES counter holds fshCs=1 for 256 ce before SEL.
  - Latency grows by 1+16+1+256 ce.
- When undefined: WAKE and the counter are absent, and behaviour is exactly as above.

Decomposition:
- Package flash_cfg_pkg:
  - command constants CMD_READ=8'h03 and CMD_RDP=8'hAB;
  - state encoding (IDLE, WAKE, SEL, XFER, DESEL);
  - VGA_CODE=2'b10;
  - TRES_CE=256.
- Sub-module spi_byte_ce: an 8-bit mode-0 shifter.
  - Inputs: clock, reset, ce, go, d[7:0].
  - Outputs: q[7:0], done, ck, mosi; input miso.
  - It runs 16 ce per byte.
- flash_cfg sequences spi_byte_ce and owns fshCs.

Test Plan:
- AUTO=1, flash model returns 0x5A,0x02 at 0x00704D → 0x03,0x00,0x70,0x4D on fshMosi MSB-first; valid=1 after 98 ce; cfgQ=16'h025A; cfgVga=1; fshCs high afterwards.
- Same flash with byte1=0x01 → cfgQ=16'h015A, cfgVga=0.
- After completion, change model byte1 to 0x02 and pulse start → busy=1; old cfgQ held during read; cfgQ and cfgVga update only at DESEL.
- start pulsed at XFER byte 2 → ignored; exactly one transaction (6 bytes) observed and fshCs stays low throughout.
- Reset driven low at ce 40 → fshCs=1, fshCk=0, valid=0, cfgQ=0 the same cycle; after release with AUTO=1 a full clean read follows.
- FLASH_CFG_WAKE_EN defined → 0xAB byte, fshCs high for 256 ce, then the READ sequence; valid at 98+274 ce.

Source files
------------

// File: rtl/flash_cfg_pkg.sv
// flash_cfg_pkg: command bytes, state encoding and timing constants
// shared by the boot-flash settings reader.
package flash_cfg_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDP  = 8'hAB;
  localparam logic [1:0] VGA_CODE = 2'b10;
  localparam int         TRES_CE  = 256;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    SEL,
    XFER,
    DESEL
  } state_t;

endpackage

// File: rtl/spi_byte_ce.sv
// spi_byte_ce: one-byte SPI mode-0 shifter, 16 ce per byte, MSB first.
// go may be raised while idle or on the done ce to chain bytes back-to-back.
module spi_byte_ce (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       go,
  input  logic [7:0] d,
  input  logic       miso,
  output logic [7:0] q,
  output logic       done,
  output logic       ck,
  output logic       mosi
);

  logic       run;
  logic [3:0] cnt;
  logic [7:0] sr;

  // done marks the ce that samples bit 0; q already includes that bit
  assign done = run && (cnt == 4'd15);
  assign q    = {sr[6:0], miso};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run  <= 1'b0;
      cnt  <= '0;
      sr   <= '0;
      ck   <= 1'b0;
      mosi <= 1'b0;
    end else if (ce) begin
      if (run && cnt[0]) begin
        ck <= 1'b1;
        sr <= {sr[6:0], miso};
      end else begin
        ck   <= 1'b0;
        mosi <= run ? sr[7] : 1'b0;
      end
      if (go) begin
        run <= 1'b1;
        cnt <= '0;
        sr  <= d;
      end else if (run) begin
        cnt <= cnt + 4'd1;
        run <= ~done;
      end
    end
  end

endmodule

// File: rtl/flash_cfg.sv
// flash_cfg: reads NBYTES settings from boot flash (READ 0x03) and holds them.
// Define FLASH_CFG_WAKE_EN to prefix each read with 0xAB and a tRES wait.
module flash_cfg
  import flash_cfg_pkg::*;
#(
  parameter logic [23:0] ADDR    = 24'h00704D,
  parameter int          NBYTES  = 2,
  parameter int          VGA_IDX = 1,
  parameter bit          AUTO    = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic                start,
  output logic                busy,
  output logic                valid,
  output logic                cfgVga,
  output logic [8*NBYTES-1:0] cfgQ,
  output logic                fshCs,
  output logic                fshCk,
  output logic                fshMosi,
  input  logic                fshMiso
);

  localparam logic [3:0] LAST = 4'(3 + NBYTES);

  state_t st, n_st;
  logic [8*NBYTES-1:0] stg, n_stg, n_q;
  logic [3:0] bcnt, n_bcnt;
  logic n_cs, n_busy, n_valid, n_vga;
  logic armed, n_armed, req, n_req;
  logic go, done;
  logic [7:0] gd, rq;
`ifdef FLASH_CFG_WAKE_EN
  logic [1:0] wph, n_wph;
  logic [7:0] wcnt, n_wcnt;
`endif

  function automatic logic [7:0] tx_byte(input logic [3:0] i);
    case (i)
      4'd0:    tx_byte = CMD_READ;
      4'd1:    tx_byte = ADDR[23:16];
      4'd2:    tx_byte = ADDR[15:8];
      4'd3:    tx_byte = ADDR[7:0];
      default: tx_byte = 8'h00;
    endcase
  endfunction

  spi_byte_ce u_spi (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .go    (go),
    .d     (gd),
    .miso  (fshMiso),
    .q     (rq),
    .done  (done),
    .ck    (fshCk),
    .mosi  (fshMosi)
  );

  always_comb begin
    n_st    = st;
    n_cs    = fshCs;
    n_busy  = busy;
    n_valid = valid;
    n_vga   = cfgVga;
    n_q     = cfgQ;
    n_stg   = stg;
    n_bcnt  = bcnt;
    n_armed = armed;
    n_req   = req;
    go      = 1'b0;
    gd      = 8'h00;
`ifdef FLASH_CFG_WAKE_EN
    n_wph   = wph;
    n_wcnt  = wcnt;
`endif
    // start can land between ce pulses, so it is held until the next ce
    if (start && (st == IDLE || st == DESEL))
      n_req = 1'b1;
    if (ce) begin
      n_armed = 1'b0;
      unique case (st)
        IDLE: begin
          if (req || start || armed) begin
            n_req  = 1'b0;
            n_busy = 1'b1;
`ifdef FLASH_CFG_WAKE_EN
            n_st   = WAKE;
`else
            n_st   = SEL;
`endif
          end
        end
`ifdef FLASH_CFG_WAKE_EN
        WAKE: begin
          unique case (wph)
            2'd0: begin
              n_cs  = 1'b0;
              go    = 1'b1;
              gd    = CMD_RDP;
              n_wph = 2'd1;
            end
            2'd1: if (done) n_wph = 2'd2;
            2'd2: begin
              n_cs   = 1'b1;
              n_wcnt = '0;
              n_wph  = 2'd3;
            end
            default: begin
              n_wcnt = wcnt + 8'd1;
              if (wcnt == 8'(TRES_CE - 1)) begin
                n_wph = 2'd0;
                n_st  = SEL;
              end
            end
          endcase
        end
`endif
        SEL: begin
          n_cs   = 1'b0;
          go     = 1'b1;
          gd     = CMD_READ;
          n_bcnt = '0;
          n_st   = XFER;
        end
        XFER: begin
          if (done) begin
            if (bcnt >= 4'd4)
              n_stg[(int'(bcnt) - 4)*8 +: 8] = rq;
            if (bcnt == LAST) begin
              n_st = DESEL;
            end else begin
              go     = 1'b1;
              gd     = tx_byte(bcnt + 4'd1);
              n_bcnt = bcnt + 4'd1;
            end
          end
        end
        DESEL: begin
          n_cs    = 1'b1;
          n_valid = 1'b1;
          n_busy  = 1'b0;
          n_q     = stg;
          n_vga   = (stg[VGA_IDX*8 +: 2] == VGA_CODE);
          n_st    = IDLE;
        end
        default: n_st = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      fshCs  <= 1'b1;
      busy   <= 1'b0;
      valid  <= 1'b0;
      cfgVga <= 1'b0;
      cfgQ   <= '0;
      stg    <= '0;
      bcnt   <= '0;
      armed  <= AUTO;
      req    <= 1'b0;
`ifdef FLASH_CFG_WAKE_EN
      wph    <= '0;
      wcnt   <= '0;
`endif
    end else begin
      st     <= n_st;
      fshCs  <= n_cs;
      busy   <= n_busy;
      valid  <= n_valid;
      cfgVga <= n_vga;
      cfgQ   <= n_q;
      stg    <= n_stg;
      bcnt   <= n_bcnt;
      armed  <= n_armed;
      req    <= n_req;
`ifdef FLASH_CFG_WAKE_EN
      wph    <= n_wph;
      wcnt   <= n_wcnt;
`endif
    end
  end

endmodule

// File: tb/tb_flash_cfg.sv
// tb_flash_cfg: randomized bench for flash_cfg against a behavioural SPI flash.
// Build with FLASH_CFG_WAKE_EN defined to cover the wake prefix.
`timescale 1ns/1ps
module tb_flash_cfg;

  localparam int          NB    = 2;
  localparam int          VIDX  = 1;
  localparam logic [23:0] FADDR = 24'h00704D;
`ifdef FLASH_CFG_WAKE_EN
  localparam int LAT = 1 + 16*(4+NB) + 1 + (1+16+1+256);
  localparam int SPT = 2;
`else
  localparam int LAT = 1 + 16*(4+NB) + 1;
  localparam int SPT = 1;
`endif
  localparam logic [63:0] RD_SEQ = {16'h0, 8'h03, FADDR, 16'h0000};

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;
  logic start = 1'b0;
  logic fshMiso = 1'b0;
  logic busy, valid, cfgVga, fshCs, fshCk, fshMosi;
  logic [8*NB-1:0] cfgQ;

  int total = 0;
  int bad = 0;
  int nce = 0;

  flash_cfg #(
    .ADDR(FADDR), .NBYTES(NB), .VGA_IDX(VIDX), .AUTO(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .ce(ce), .start(start),
    .busy(busy), .valid(valid), .cfgVga(cfgVga), .cfgQ(cfgQ),
    .fshCs(fshCs), .fshCk(fshCk), .fshMosi(fshMosi),
    .fshMiso(fshMiso)
  );

  always #5 clock = ~clock;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clock);
      ce = (div == 0);
      div = (div + 1) % 4;
    end
  end

  always @(posedge clock) if (ce) nce <= nce + 1;

  // behavioural flash: memory image at FADDR, answers only READ
  logic [7:0] mem [8];
  logic [7:0] rx [$];
  logic [7:0] sess [$];
  logic [7:0] sh = 8'h00;
  logic [7:0] fb;
  logic pck = 1'b0;
  logic pcs = 1'b1;
  int nbit = 0;
  int nsess = 0;
  int csviol = 0;
  int fk;

  function automatic logic [7:0] frd(input logic [23:0] a);
    logic [23:0] off;
    off = a - FADDR;
    return (off < 24'd8) ? mem[off[2:0]] : 8'hFF;
  endfunction

  always @(fshCk or fshCs) begin
    if (pcs === 1'b1 && fshCs === 1'b0) begin
      nbit = 0;
      rx.delete();
    end
    if (pcs === 1'b0 && fshCs === 1'b1) begin
      sess = rx;
      nsess++;
    end
    if (pck === 1'b0 && fshCk === 1'b1) begin
      if (fshCs !== 1'b0) csviol++;
      else begin
        sh = {sh[6:0], fshMosi};
        nbit++;
        if (nbit % 8 == 0) rx.push_back(sh);
      end
    end
    if (pck === 1'b1 && fshCk === 1'b0) begin
      if (fshCs === 1'b0 && nbit >= 32 && rx[0] == 8'h03) begin
        fk = nbit - 32;
        fb = frd({rx[1], rx[2], rx[3]} + 24'(fk / 8));
        fshMiso = fb[3'(7 - fk % 8)];
      end
    end
    pck = fshCk;
    pcs = fshCs;
  end

  function automatic logic [8*NB-1:0] exp_q();
    logic [8*NB-1:0] v;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = mem[i];
    return v;
  endfunction

  function automatic logic exp_vga();
    return mem[VIDX][1:0] == 2'b10;
  endfunction

  function automatic logic [63:0] pk();
    logic [63:0] v;
    v = '0;
    foreach (sess[i]) v = {v[55:0], sess[i]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic next_ce();
    do cyc(); while (ce !== 1'b1);
  endtask

  task automatic launch(output int n0);
    next_ce();
    n0 = nce;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int n0, output int lat, output bit held);
    logic [8*NB-1:0] q0;
    logic v0;
    int g;
    q0 = cfgQ;
    v0 = cfgVga;
    held = 1'b1;
    g = 0;
    while (busy !== 1'b0 && g < 4000) begin
      if (cfgQ !== q0 || cfgVga !== v0) held = 1'b0;
      cyc();
      g++;
    end
    if (g >= 4000) chk("idle_timeout", 64'(g), 0);
    lat = nce - n0 - 1;
  endtask

  task automatic auto_wait(input int n0, output int lat);
    int g;
    g = 0;
    while (valid !== 1'b1 && g < 4000) begin
      cyc();
      g++;
    end
    if (g >= 4000) chk("valid_timeout", 64'(g), 0);
    lat = nce - n0 - 1;
  endtask

  task automatic wait_rx(input int n);
    int g;
    g = 0;
    while (!(fshCs === 1'b0 && rx.size() == n && rx[0] == 8'h03)
           && g < 4000) begin
      cyc();
      g++;
    end
    if (g >= 4000) chk("rx_timeout", 64'(g), 0);
  endtask

  initial begin
    int n0, lat, s0;
    bit held, saw;
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h5A;
    mem[1] = 8'h02;

    reset = 1'b0;
    repeat (6) cyc();
    chk("rst_cs", fshCs, 1);
    chk("rst_ck", fshCk, 0);
    chk("rst_mosi", fshMosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_q", cfgQ, 0);
    chk("rst_vga", cfgVga, 0);

    s0 = nsess;
    n0 = nce;
    reset = 1'b1;
    auto_wait(n0, lat);
    chk("auto_lat", lat, LAT);
    chk("auto_q", cfgQ, exp_q());
    chk("auto_vga", cfgVga, exp_vga());
    chk("auto_cs", fshCs, 1);
    chk("auto_busy", busy, 0);
    chk("auto_seq", pk(), RD_SEQ);
    chk("auto_sess", nsess - s0, SPT);

    mem[1] = 8'h01;
    launch(n0);
    chk("st_busy", busy, 1);
    wait_idle(n0, lat, held);
    chk("b1_lat", lat, LAT);
    chk("b1_hold", held, 1);
    chk("b1_q", cfgQ, exp_q());
    chk("b1_vga", cfgVga, exp_vga());

    mem[1] = 8'h02;
    launch(n0);
    chk("re_busy", busy, 1);
    wait_idle(n0, lat, held);
    chk("re_hold", held, 1);
    chk("re_q", cfgQ, exp_q());
    chk("re_vga", cfgVga, exp_vga());
    chk("re_valid", valid, 1);

    s0 = nsess;
    mem[0] = 8'($urandom);
    launch(n0);
    wait_rx(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle(n0, lat, held);
    chk("busy_lat", lat, LAT);
    chk("busy_sess", nsess - s0, SPT);
    chk("busy_seq", pk(), RD_SEQ);
    chk("busy_q", cfgQ, exp_q());
    saw = 1'b0;
    repeat (160) begin
      cyc();
      if (busy !== 1'b0) saw = 1'b1;
    end
    chk("busy_dropped", saw, 0);

    s0 = nsess;
    launch(n0);
    wait_rx(4 + NB);
    next_ce();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("desel_valid", valid, 1);
    saw = 1'b0;
    repeat (20) begin
      cyc();
      if (busy === 1'b1) saw = 1'b1;
    end
    chk("desel_relaunch", saw, 1);
    wait_idle(n0, lat, held);
    chk("desel_sess", nsess - s0, 2 * SPT);

    for (int it = 0; it < 6; it++) begin
      mem[0] = 8'($urandom);
      mem[1] = 8'($urandom);
      repeat ($urandom_range(0, 5)) cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      saw = 1'b0;
      repeat (12) begin
        if (busy === 1'b1) saw = 1'b1;
        cyc();
      end
      chk("rnd_launch", saw, 1);
      wait_idle(nce, lat, held);
      chk("rnd_hold", held, 1);
      chk("rnd_q", cfgQ, exp_q());
      chk("rnd_vga", cfgVga, exp_vga());
    end

    launch(n0);
    while (nce - n0 < 40) cyc();
    reset = 1'b0;
    #1;
    chk("mid_cs", fshCs, 1);
    chk("mid_ck", fshCk, 0);
    chk("mid_valid", valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_q", cfgQ, 0);
    repeat (3) cyc();
    mem[0] = 8'($urandom);
    mem[1] = {6'($urandom), 2'b10};
    s0 = nsess;
    n0 = nce;
    reset = 1'b1;
    auto_wait(n0, lat);
    chk("rec_lat", lat, LAT);
    chk("rec_q", cfgQ, exp_q());
    chk("rec_vga", cfgVga, exp_vga());
    chk("rec_seq", pk(), RD_SEQ);
    chk("rec_sess", nsess - s0, SPT);

    chk("cs_at_ck", csviol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
